// File: rtl/ex_fwd_hazard_unit.sv
// Purpose : EX-stage operand forwarding plus hazard control. It tracks the
//           destination tags of in-flight instructions (EX, MEM, WB) and
//           produces registered forwarding selects, a load-use and HI/LO
//           (mult/div busy) stall, flush-aware bubble insertion and a
//           saturating stall counter.
// Latency : fwd_sel is registered and becomes valid in the cycle the ID
//           instruction occupies EX. stall is combinational from the ID
//           inputs and the tracked tags. mdu_busy and stall_cnt are
//           register-derived.
// Backpressure: stall holds PC and IF/ID and turns the EX slot into a
//           bubble. flush overrides any hazard: there is no stall, and a
//           bubble is inserted.
// Ports   : clk, reset (async, active-high);
//           id_valid, id_src, id_dst, id_regwrite, id_memread,
//           id_mdu_start, id_mdu_read, flush (ID-stage control in);
//           stall, fwd_sel, mdu_busy, stall_cnt (out).
// Option  : WB_HOLD_FWD_EN enables a third forwarding level (code 11) from
//           a WB-hold stage, for register files without write-first bypass.
module ex_fwd_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int MDU_LAT    = 4,
   parameter int CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_src,
   input  logic [REG_ADDR_W-1:0]          id_dst,
   input  logic                           id_regwrite,
   input  logic                           id_memread,
   input  logic                           id_mdu_start,
   input  logic                           id_mdu_read,
   input  logic                           flush,
   output logic                           stall,
   output logic [NUM_SRC*2-1:0]           fwd_sel,
   output logic                           mdu_busy,
   output logic [CNT_W-1:0]               stall_cnt
);

   typedef struct packed {
      logic                  rw;
      logic                  ld;
      logic [REG_ADDR_W-1:0] dst;
   } tag_t;

   localparam logic [3:0]       MDU_LOAD = 4'(MDU_LAT);
   localparam logic [3:0]       MDU_ONE  = 4'd1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   tag_t ex_t;
   tag_t mem_t;
   tag_t wb_t;
`ifdef WB_HOLD_FWD_EN
   tag_t hold_t;
`endif

   logic [3:0]           mdu_cnt;
   logic                 load_use;
   logic                 mdu_hz;
   logic                 issue;
   logic [NUM_SRC*2-1:0] fwd_raw;
   logic [NUM_SRC*2-1:0] fwd_nxt;

   // A tag only counts as a producer when it writes a non-zero register.
   function automatic logic match(input tag_t t, input logic [REG_ADDR_W-1:0] a);
      return t.rw && (t.dst != '0) && (t.dst == a);
   endfunction

   // Nearest in-flight producer wins. The select is computed while the
   // consumer is in ID, so a producer now in EX will be in MEM (EX/MEM
   // bypass) during the consumer's EX cycle. A producer now in MEM will be
   // in WB (MEM/WB bypass).
   always_comb begin
      load_use = 1'b0;
      fwd_raw  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_t.ld && match(ex_t, id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
            load_use = 1'b1;
         end
         if (match(ex_t, id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
            fwd_raw[i*2 +: 2] = 2'b01;
         end else if (match(mem_t, id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
            fwd_raw[i*2 +: 2] = 2'b10;
`ifdef WB_HOLD_FWD_EN
         end else if (match(wb_t, id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
            fwd_raw[i*2 +: 2] = 2'b11;
`endif
         end
      end
   end

   assign mdu_busy = (mdu_cnt != 4'd0);
   // A new launch while busy is held too, so an in-flight op is never overwritten.
   assign mdu_hz   = mdu_busy && (id_mdu_read || id_mdu_start);
   // flush dominates: a squashed instruction can never cause a stall.
   assign stall    = id_valid && !flush && (load_use || mdu_hz);
   assign issue    = id_valid && !flush && !stall;
   // Bubbles carry no operands, so their selects are forced to the regfile.
   assign fwd_nxt  = issue ? fwd_raw : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_t    <= '0;
         mem_t   <= '0;
         wb_t    <= '0;
         fwd_sel <= '0;
      end else begin
         mem_t   <= ex_t;
         wb_t    <= mem_t;
         fwd_sel <= fwd_nxt;
         if (issue) begin
            ex_t.rw  <= id_regwrite;
            ex_t.ld  <= id_memread;
            ex_t.dst <= id_dst;
         end else begin
            ex_t <= '0;
         end
      end
   end

`ifdef WB_HOLD_FWD_EN
   // The tag of the result that the datapath holds for one cycle after WB.
   // It is the source of select code 11 during the consumer's EX cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_t <= '0;
      end else begin
         hold_t <= wb_t;
      end
   end
`endif

   // The mult/div busy counter is launched only by an instruction that
   // actually issues. A later flush does not cancel an op that is already
   // in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdu_cnt <= 4'd0;
      end else if (issue && id_mdu_start) begin
         mdu_cnt <= MDU_LOAD;
      end else if (mdu_cnt != 4'd0) begin
         mdu_cnt <= mdu_cnt - MDU_ONE;
      end
   end

   // The stall counter saturates at all-ones. It does not wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   // These tag fields only trail the pipeline; no select reads them.
   logic unused_tags;
`ifdef WB_HOLD_FWD_EN
   assign unused_tags = ^{mem_t.ld, wb_t.ld, hold_t};
`else
   assign unused_tags = ^{mem_t.ld, wb_t};
`endif

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
module tb_ex_fwd_hazard_unit;

   localparam int AW      = 5;
   localparam int NSRC    = 2;
   localparam int LAT     = 4;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef WB_HOLD_FWD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 id_valid = 1'b0;
   logic [NSRC*AW-1:0]   id_src = '0;
   logic [AW-1:0]        id_dst = '0;
   logic                 id_regwrite = 1'b0;
   logic                 id_memread = 1'b0;
   logic                 id_mdu_start = 1'b0;
   logic                 id_mdu_read = 1'b0;
   logic                 flush = 1'b0;
   logic                 stall;
   logic [NSRC*2-1:0]    fwd_sel;
   logic                 mdu_busy;
   logic [CW-1:0]        stall_cnt;

   int checks = 0;
   int errors = 0;

   ex_fwd_hazard_unit #(
      .REG_ADDR_W(AW), .NUM_SRC(NSRC), .MDU_LAT(LAT), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .flush(flush),
      .stall(stall), .fwd_sel(fwd_sel), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- Reference model ----------------
   // The pipeline is modelled as an array of in-flight instructions,
   // indexed by distance from ID (0 = EX, 1 = MEM, 2 = WB).
   int          m_rw[3];
   int          m_ld[3];
   int          m_dst[3];
   int          m_mdu;
   int          m_cnt;
   logic [3:0]  m_fwd;
   logic        exp_stall;

   function automatic bit producer_at(int s, int a);
      return (m_rw[s] != 0) && (m_dst[s] != 0) && (m_dst[s] == a);
   endfunction

   function automatic int src_of(int i);
      logic [NSRC*AW-1:0] v;
      v = id_src;
      return int'(v[i*AW +: AW]);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         m_rw[s] = 0; m_ld[s] = 0; m_dst[s] = 0;
      end
      m_mdu = 0; m_cnt = 0; m_fwd = '0; exp_stall = 1'b0;
   endtask

   // Apply ID inputs just after a rising edge, then move to the falling edge
   // and work out whether the model expects a stall this cycle.
   task automatic drive(input bit v, input int s0, input int s1, input int d,
                        input bit rw, input bit ld, input bit ms, input bit mr,
                        input bit fl);
      bit lu;
      id_valid = v; id_src = {5'(s1), 5'(s0)}; id_dst = 5'(d);
      id_regwrite = rw; id_memread = ld; id_mdu_start = ms; id_mdu_read = mr;
      flush = fl;
      @(negedge clk);
      lu = 1'b0;
      for (int i = 0; i < NSRC; i++)
         if (m_ld[0] != 0 && producer_at(0, src_of(i))) lu = 1'b1;
      exp_stall = v && !fl && (lu || (m_mdu > 0 && (mr || ms)));
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance the model by one cycle, then step past the next rising edge.
   task automatic tick();
      bit issue;
      int code;
      int depth;
      issue = id_valid && !flush && !exp_stall;
      depth = HOLD ? 3 : 2;
      for (int i = 0; i < NSRC; i++) begin
         code = 0;
         if (issue)
            for (int s = depth - 1; s >= 0; s--)
               if (producer_at(s, src_of(i))) code = s + 1;
         m_fwd[i*2 +: 2] = 2'(code);
      end
      for (int s = 2; s > 0; s--) begin
         m_rw[s] = m_rw[s-1]; m_ld[s] = m_ld[s-1]; m_dst[s] = m_dst[s-1];
      end
      m_rw[0]  = issue ? int'(id_regwrite) : 0;
      m_ld[0]  = issue ? int'(id_memread) : 0;
      m_dst[0] = issue ? int'(id_dst) : 0;
      if (issue && id_mdu_start) m_mdu = LAT;
      else if (m_mdu > 0)        m_mdu = m_mdu - 1;
      if (exp_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      id_valid = 0; id_mdu_start = 0; id_mdu_read = 0; flush = 0;
      id_regwrite = 0; id_memread = 0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({stall, fwd_sel, mdu_busy, stall_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_initial: got stall=%b fwd=%b busy=%b cnt=%0d, need all 0",
                  stall, fwd_sel, mdu_busy, stall_cnt);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      // Build up live state, then assert reset between clock edges.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();   // mult
      drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();   // lw $5
      drive(1, 5, 0, 8, 1, 0, 0, 1, 0);           // mflo reading $5
      checks++;
      if (stall !== 1'b1 || mdu_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_prestate: got stall=%b busy=%b, need 1 1", stall, mdu_busy);
      end
      tick();
      drive(1, 5, 0, 8, 1, 0, 0, 1, 0);
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL reset_precnt: got %0d, need 1", stall_cnt);
      end
      #2;
      reset = 1'b1;
      id_valid = 0; id_mdu_read = 0; id_regwrite = 0;
      #1;
      checks++;
      if ({stall, fwd_sel, mdu_busy, stall_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_async: got stall=%b fwd=%b busy=%b cnt=%0d, need all 0",
                  stall, fwd_sel, mdu_busy, stall_cnt);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, 1, 2, 3, 1, 0, 0, 0, 0); tick();   // add $3
      drive(1, 3, 7, 4, 1, 0, 0, 0, 0); tick();   // sub reads $3
      idle();
      checks++;
      if (fwd_sel !== 4'b0001 || fwd_sel !== m_fwd) begin
         errors++;
         $display("FAIL b2b_ex_mem: got %b, need %b", fwd_sel, 4'b0001);
      end
      tick(); idle(); tick(); idle(); tick();
      drive(1, 1, 2, 3, 1, 0, 0, 0, 0); tick();   // add $3
      drive(1, 1, 2, 9, 1, 0, 0, 0, 0); tick();   // unrelated
      drive(1, 3, 0, 4, 1, 0, 0, 0, 0); tick();   // reads $3
      idle();
      checks++;
      if (fwd_sel !== 4'b0010 || fwd_sel !== m_fwd) begin
         errors++;
         $display("FAIL b2b_mem_wb: got %b, need %b", fwd_sel, 4'b0010);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();   // lw $5
      drive(1, 1, 5, 6, 1, 0, 0, 0, 0);           // add reads $5 as src1
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL lu_stall: got %b, need 1", stall);
      end
      tick();
      drive(1, 1, 5, 6, 1, 0, 0, 0, 0);
      checks++;
      if (stall !== 1'b0 || stall_cnt !== 4'd1 || fwd_sel !== 4'b0000) begin
         errors++;
         $display("FAIL lu_release: got stall=%b cnt=%0d fwd=%b, need 0 1 0000",
                  stall, stall_cnt, fwd_sel);
      end
      tick();
      idle();
      checks++;
      if (fwd_sel !== 4'b1000) begin
         errors++;
         $display("FAIL lu_fwd: got %b, need 1000", fwd_sel);
      end
      tick();
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0); tick();   // lw $0
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0);           // reads $0 twice
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL r0_nostall: got %b, need 0", stall);
      end
      tick();
      idle();
      checks++;
      if (fwd_sel !== 4'b0000) begin
         errors++;
         $display("FAIL r0_fwd: got %b, need 0000", fwd_sel);
      end
      tick();
   endtask

   task automatic test_mdu();
      int n;
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();   // mult
      n = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 0, 8, 1, 0, 0, 1, 0);        // mflo
         checks++;
         if (stall !== exp_stall) begin
            errors++;
            $display("FAIL mdu_stall_model: got %b, need %b", stall, exp_stall);
         end
         if (!stall) break;
         n++;
         tick();
      end
      checks++;
      if (n != LAT || mdu_busy !== 1'b0) begin
         errors++;
         $display("FAIL mdu_hold: got %0d stalls busy=%b, need %0d busy=0", n, mdu_busy, LAT);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();   // mult
      drive(1, 0, 0, 8, 1, 0, 0, 1, 1);           // mflo, flushed
      checks++;
      if (stall !== 1'b0 || mdu_busy !== 1'b1) begin
         errors++;
         $display("FAIL mdu_flush: got stall=%b busy=%b, need 0 1", stall, mdu_busy);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         idle();
         checks++;
         if (mdu_busy !== (k < 3)) begin
            errors++;
            $display("FAIL mdu_countdown%0d: got %b, need %b", k, mdu_busy, (k < 3));
         end
         tick();
      end
   endtask

   task automatic test_flush_priority();
      do_reset();
      drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();   // lw $5
      drive(1, 5, 5, 6, 1, 0, 0, 0, 1);           // add reads $5, flushed
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall: got %b, need 0", stall);
      end
      tick();
      idle();
      checks++;
      if (fwd_sel !== 4'b0000 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL flush_bubble: got fwd=%b cnt=%0d, need 0000 0", fwd_sel, stall_cnt);
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int r = 0; r < 6; r++) begin
         drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
         for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 8, 1, 0, 0, 1, 0);
            checks++;
            if (stall_cnt !== 4'(m_cnt)) begin
               errors++;
               $display("FAIL sat_track: got %0d, need %0d", stall_cnt, m_cnt);
            end
            if (!exp_stall) begin
               tick();
               break;
            end
            tick();
         end
      end
      idle();
      checks++;
      if (stall_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_final: got %0d, need 15", stall_cnt);
      end
      tick();
   endtask

   task automatic test_wb_hold();
      logic [1:0] need;
      do_reset();
      need = HOLD ? 2'b11 : 2'b00;
      drive(1, 0, 0, 6, 1, 0, 0, 0, 0); tick();   // producer of $6
      drive(1, 1, 2, 9, 1, 0, 0, 0, 0); tick();
      drive(1, 1, 2, 10, 1, 0, 0, 0, 0); tick();
      drive(1, 6, 0, 11, 1, 0, 0, 0, 0); tick();  // consumer of $6
      idle();
      checks++;
      if (fwd_sel[1:0] !== need) begin
         errors++;
         $display("FAIL wb_hold: got %b, need %b", fwd_sel[1:0], need);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
               $urandom_range(7), $urandom_range(1), $urandom_range(99) < 30,
               $urandom_range(99) < 10, $urandom_range(99) < 15,
               $urandom_range(99) < 10);
         checks++;
         if (stall !== exp_stall || fwd_sel !== m_fwd ||
             mdu_busy !== (m_mdu > 0) || stall_cnt !== 4'(m_cnt)) begin
            errors++;
            $display("FAIL random_c%0d: got stall=%b fwd=%b busy=%b cnt=%0d, need %b %b %b %0d",
                     c, stall, fwd_sel, mdu_busy, stall_cnt,
                     exp_stall, m_fwd, (m_mdu > 0), m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_mdu();
      test_flush_priority();
      test_saturation();
      test_wb_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_fwd_hazard_unit.md
Name: ex_fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit; generalises forwarding and adds hazard handling.
- Internally tracks the destination tags of in-flight instructions (EX, MEM, WB).
- Produces registered forwarding selects for an arbitrary number of source operands, one cycle ahead of EX use.
- Adds load-use stall detection, a multiply/divide (HI/LO) busy interlock, flush handling and a saturating stall counter.
- Sits between the ID/EX pipeline register control and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5, register address width; address 0 is the hardwired-zero register.
- NUM_SRC, 2, source operands per instruction (rs, rt, ...).
- MDU_LAT, 4, cycles the multiply/divide unit stays busy after launch (1..15).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  packed source addresses; src i at [i*REG_ADDR_W +: REG_ADDR_W].
- id_dst  in  REG_ADDR_W  destination register of ID instruction.
- id_regwrite  in  1  ID instruction writes id_dst.
- id_memread  in  1  ID instruction is a load.
- id_mdu_start  in  1  ID instruction launches mult/div.
- id_mdu_read  in  1  ID instruction reads HI/LO (mfhi/mflo).
- flush  in  1  squash ID instruction (branch/jump redirect).
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- fwd_sel  out  NUM_SRC*2  registered; per-source select valid during EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB-hold (optional).
- mdu_busy  out  1  mult/div counter non-zero.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Tag registers ex_t, mem_t, wb_t, each {rw, ld, dst}. Reset: all fields 0, fwd_sel=0, mdu counter=0, stall_cnt=0. stall and mdu_busy are therefore 0 after reset.
- Match(tag, a) = tag.rw && tag.dst!=0 && tag.dst==a.
- stall = id_valid && !flush && (load_use || mdu_hz).
  - load_use: ex_t.ld && Match(ex_t, any id_src).
  - mdu_hz: mdu_busy && (id_mdu_read || id_mdu_start).
- Per cycle, priority reset > others:
  - mem_t<=ex_t, wb_t<=mem_t unconditionally.
  - ex_t <= {id_regwrite,id_memread,id_dst} when id_valid && !flush && !stall; else bubble (all 0).
- fwd_sel[i] next value, nearest stage wins: Match(ex_t,src_i) -> 01; else Match(mem_t,src_i) -> 10; else 00.
  - Forced to 00 when a bubble is inserted (stall, flush or !id_valid).
  - Latency: selects appear exactly one cycle after the instruction leaves ID, aligned with its EX cycle.
- After a load-use stall, the following cycle recomputes; the load is then in mem_t, giving 10. Exactly one bubble per load-use.
- MDU counter:
  - Loads MDU_LAT when id_mdu_start && id_valid && !flush && !stall.
  - Otherwise decrements while non-zero.
  - mdu_busy = (counter != 0).
  - flush does not cancel an already-launched MDU op.
- stall_cnt increments on each cycle stall=1 and saturates at all-ones (no wrap).
- Simultaneous flush+hazard: flush wins; stall=0 and a bubble is inserted.
- Reset asserted mid-operation clears all state immediately, asynchronously.

Optional Feature:
- Macro WB_HOLD_FWD_EN.
- Defined: extra tag hold_t <= wb_t. fwd_sel priority gains a third level: Match(wb_t,src_i) -> 11 when neither ex_t nor mem_t matches. This supports a register file without write-first bypass.
- Undefined: no hold_t; code 11 is never produced; the register file must provide write-through.

Test Plan:
- Reset: assert reset mid-run -> stall=0, fwd_sel=0, mdu_busy=0, stall_cnt=0 immediately.
- Back-to-back ALU: add $3 then sub reading $3 as src0 -> fwd_sel[1:0]=01 in sub's EX cycle; with one unrelated instruction between -> 10.
- Load-use: lw $5 then add reading $5 as src1 -> stall=1 for exactly one cycle, stall_cnt=1, add's EX cycle fwd_sel[3:2]=10; writes to $0 never forward (fwd_sel=00).
- MDU: mult then mflo next cycle with MDU_LAT=4 -> stall held 4 cycles, mflo issues when mdu_busy falls; flush during busy -> counter continues.
- Flush priority: load-use condition plus flush=1 -> stall=0, bubble inserted, next fwd_sel=00.
- WB_HOLD_FWD_EN defined: producer three instructions ahead of consumer -> fwd_sel=11; undefined -> 00.
